// File: rtl/fetch_mem_ctrl.sv
// Single-port RAM master: instruction prefetch queue feeding decode, sharing the port with
// execute-stage load/store requests, which take priority.
module fetch_mem_ctrl #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       INSTR_W  = 16,
  parameter int unsigned       QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ram_rw,
  output logic [ADDR_W-1:0]  ram_adrs,
  output logic [DATA_W-1:0]  ram_din,
  input  logic [INSTR_W-1:0] ram_dout,
  input  logic               ls_req,
  input  logic               ls_we,
  input  logic [ADDR_W-1:0]  ls_adrs,
  input  logic [DATA_W-1:0]  ls_wdata,
  output logic               ls_ack,
  output logic [INSTR_W-1:0] ls_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_pc
);

  localparam int unsigned     PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned     CntW = $clog2(QDEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(QDEPTH);

  typedef enum logic [0:0] {StIdle, StAck} ls_state_e;

  ls_state_e          state_q;
  logic [ADDR_W-1:0]  fetch_pc_q;
  logic [CntW-1:0]    count_q;
  logic [PtrW-1:0]    rptr_q, wptr_q;
  logic [INSTR_W-1:0] q_data [QDEPTH];
  logic [ADDR_W-1:0]  q_pc   [QDEPTH];

  logic ls_slot, push, pop;

  // The load/store request owns the port only in its first cycle; the ACK cycle is free for fetch.
  assign ls_slot  = (state_q == StIdle) && ls_req;
  assign ram_adrs = ls_slot ? ls_adrs : fetch_pc_q;
  assign ram_din  = ls_slot ? ls_wdata : '0;
  assign ram_rw   = ls_slot && ls_we && !rst;

  assign ir_valid = (count_q != '0);
  assign ir_data  = ir_valid ? q_data[rptr_q] : '0;
  assign ir_pc    = ir_valid ? q_pc[rptr_q] : '0;

  // A full queue refuses the push even when the head pops this cycle.
  assign push = !ls_slot && !redirect && !rst && (count_q != Full);
  assign pop  = ir_valid && ir_ready && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ls_ack   <= 1'b0;
      ls_rdata <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ls_req) begin
            state_q <= StAck;
            ls_ack  <= 1'b1;
            if (!ls_we) ls_rdata <= ram_dout;
          end
        end
        StAck: begin
          state_q <= StIdle;
          ls_ack  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
    end else begin
      if (push) begin
        wptr_q     <= wptr_q + PtrW'(1);
        fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wptr_q] <= ram_dout;
      q_pc[wptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: doc/fetch_mem_ctrl.md
Name: fetch_mem_ctrl

Overview:
- Sole master of the 256-entry RAM port: adrs, rw, din, and the 16-bit dout.
- Fetches 16-bit instruction words in address order into a small prefetch queue, which feeds decode through a valid/ready handshake.
- Shares the single RAM port with the execute stage's load/store requests; load/store has priority.
- Handles control-flow redirects by flushing the queue and restarting fetch at the new address.

Parameters:
- ADDR_W, 8, RAM address width; PC width.
- DATA_W, 8, store data width (RAM din).
- INSTR_W, 16, RAM read width; instruction width.
- QDEPTH, 4, prefetch queue entries; must be a power of two, at least 2.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ram_rw  out  1  RAM write enable; 1 = write this cycle.
- ram_adrs  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  INSTR_W  RAM read data; asynchronous read of mem[ram_adrs].
- ls_req  in  1  load/store request; held high until ls_ack.
- ls_we  in  1  1 = store, 0 = load.
- ls_adrs  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_ack  out  1  one-cycle completion pulse.
- ls_rdata  out  INSTR_W  load result; valid while ls_ack = 1, held until the next load completes.
- redirect  in  1  flush queue and restart fetch.
- redirect_pc  in  ADDR_W  new fetch address.
- ir_valid  out  1  queue head valid.
- ir_ready  in  1  decode accepts head.
- ir_data  out  INSTR_W  head instruction.
- ir_pc  out  ADDR_W  address of head instruction.

Behaviour:
- Reset (sync, rst = 1 at a clk edge):
  - Register values: fetch_pc = RESET_PC, queue count = rptr = wptr = 0, load/store FSM = IDLE, ls_ack = 0, ls_rdata = 0.
  - Resulting outputs: ir_valid = 0, ir_data = ir_pc = 0 while the queue is empty.
  - While rst is high, ram_rw is forced to 0 combinationally.
  - Reset mid-operation drops any pending load/store without an ack and discards queue contents.
- RAM port mux (combinational), exactly one owner per cycle:
  - LS slot (FSM = IDLE and ls_req = 1): ram_adrs = ls_adrs, ram_rw = ls_we, ram_din = ls_wdata.
  - Otherwise: ram_adrs = fetch_pc, ram_rw = 0, ram_din = 0.
  - ram_rw = 1 only in an LS slot with ls_we = 1; never in fetch or idle cycles.
- Load/store FSM:
  - IDLE: if ls_req, perform the access and capture ls_rdata <= ram_dout (loads only; stores leave ls_rdata unchanged), then go to ACK.
  - ACK: ls_ack = 1, then return to IDLE. The RAM port is free for fetch in this cycle.
  - ls_req seen in ACK is ignored. The requester must drop ls_req in the ACK cycle; if ls_req is still high in the following IDLE cycle, it is a new request.
  - Latency: request cycle N, ack cycle N+1, so at most one load/store every 2 cycles.
  - Load data = full 16-bit word. Stores write {8'h00, ls_wdata} (RAM zero-extends).
- Fetch:
  - Fetch occurs in any cycle with no LS slot, redirect = 0, rst = 0, and count < QDEPTH.
  - On fetch: push {ram_dout, fetch_pc} at wptr; fetch_pc <= fetch_pc + 1, wrapping 8'hFF -> 8'h00.
  - A full queue blocks the push even if a pop occurs in the same cycle.
- Queue:
  - Pop when ir_valid & ir_ready: rptr advances.
  - count <= count + push - pop. Simultaneous push and pop leaves count unchanged.
  - ir_valid = (count != 0). ir_data and ir_pc come from the entry at rptr.
  - Pointers wrap modulo QDEPTH.
- Redirect (priority over fetch and pop):
  - Next state: count = 0, rptr = wptr = 0, fetch_pc = redirect_pc. No fetch or pop in that cycle.
  - An LS slot in the redirect cycle still executes.
  - First fetch from redirect_pc happens the cycle after, earliest; ir_valid returns one cycle after that.
- Coherence: no snooping. A store to an already-prefetched address leaves a stale queue entry; control must redirect after self-modifying stores.

Test Plan:
- Reset with mem[0..4] = 16'h0101,16'h0202,16'h0303,16'h0404,16'h0505, ir_ready = 0, release rst
  -> ram_rw = 0 throughout.
  -> After 4 fetch cycles, count = 4 and ram_adrs holds at 4.
  -> ir_valid = 1, ir_data = 16'h0101, ir_pc = 0.
- ir_ready = 1 continuously from RESET_PC = 8'hFE
  -> ir_pc sequence is FE, FF, 00, 01, one per cycle after the first-fill cycle; wrap verified.
- While streaming, load at ls_adrs = 8'h80 with mem[80] = 16'h00C3
  -> Request cycle: ram_adrs = 80, no push.
  -> Next cycle: ls_ack = 1, ls_rdata = 16'h00C3, and fetch resumes in that cycle.
- Store: ls_we = 1, ls_adrs = 8'h90, ls_wdata = 8'hA5
  -> ram_rw = 1 for exactly one cycle.
  -> A subsequent load of 8'h90 returns 16'h00A5.
- Queue holds 3 entries at pc 10..12, pulse redirect with redirect_pc = 8'h40
  -> Next cycle: ir_valid = 0.
  -> Two cycles later: ir_valid = 1, ir_pc = 40, ir_data = mem[40]; old entries never appear.
- rst asserted in the ACK-pending cycle of a load, and ls_req and redirect asserted together
  -> Reset case: ls_ack stays 0 and ram_rw = 0.
  -> Combined case: LS access executes, queue flushes, and the ack follows on the next cycle.
